// File: rtl/stavka_a_pkg.sv
// rtl/stavka_a_pkg.sv - shared constants and types for the stavka_a parity encoder
package stavka_a_pkg;

  localparam int DATA_W_DEFAULT = 7;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef logic [DATA_W_DEFAULT:0] code_word_t;

endpackage

// File: rtl/stavka_a_parity_gen.sv
// rtl/stavka_a_parity_gen.sv - combinational parity bit and optional ones count (STAVKA_A_ONES_COUNT_EN)
module parity_gen
  import stavka_a_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0]             data,
  input  logic                          odd,
  output logic                          parity
`ifdef STAVKA_A_ONES_COUNT_EN
  ,
  output logic [$clog2(DATA_W+2)-1:0]   ones_count
`endif
);

  // Odd sense flips the even-parity bit so the whole code word carries an odd number of ones.
  always_comb begin
    parity = (^data) ^ (odd == PARITY_ODD);
  end

`ifdef STAVKA_A_ONES_COUNT_EN
  localparam int CW = $clog2(DATA_W + 2);

  logic [CW-1:0] w_cnt;

  // Population count of the full code word: data bits plus the parity bit just computed.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_cnt = w_cnt + CW'(data[i]);
    end
    ones_count = w_cnt + CW'(parity);
  end
`endif

endmodule

// File: rtl/stavka_a.sv
// rtl/stavka_a.sv - registered 7+1 parity encoder top; STAVKA_A_ONES_COUNT_EN adds a registered ones count
module stavka_a
  import stavka_a_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          control,
  output logic [DATA_W:0]               data_out
`ifdef STAVKA_A_ONES_COUNT_EN
  ,
  output logic [$clog2(DATA_W+2)-1:0]   ones_count
`endif
);

  logic             w_parity;
  logic [DATA_W:0]  r_data_out;

`ifdef STAVKA_A_ONES_COUNT_EN
  logic [$clog2(DATA_W+2)-1:0] w_ones_count;
  logic [$clog2(DATA_W+2)-1:0] r_ones_count;
`endif

  parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .data       (data_in),
    .odd        (control),
    .parity     (w_parity)
`ifdef STAVKA_A_ONES_COUNT_EN
    ,
    .ones_count (w_ones_count)
`endif
  );

  // Single output stage: data keeps its bit order above the parity bit in position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else begin
      r_data_out <= {data_in, w_parity};
    end
  end

  assign data_out = r_data_out;

`ifdef STAVKA_A_ONES_COUNT_EN
  // Ones count is captured on the same edge as the code word so the two always describe one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_count <= '0;
    end else begin
      r_ones_count <= w_ones_count;
    end
  end

  assign ones_count = r_ones_count;
`endif

endmodule

// File: tb/tb_stavka_a.sv
// tb/tb_stavka_a.sv - self-checking bench for stavka_a (optionally with STAVKA_A_ONES_COUNT_EN)
module tb_stavka_a;
  import stavka_a_pkg::*;

  localparam int DW = DATA_W_DEFAULT;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          control;
  code_word_t    data_out;
`ifdef STAVKA_A_ONES_COUNT_EN
  logic [3:0]    ones_count;
`endif

  int errors;
  int checks;

  stavka_a #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .control    (control),
    .data_out   (data_out)
`ifdef STAVKA_A_ONES_COUNT_EN
    ,
    .ones_count (ones_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the code word must hold the data and make its total ones count match the parity sense.
  function automatic code_word_t ref_word(input logic [DW-1:0] d, input logic c);
    int ones;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return {d, ((ones % 2) == 1) != c};
  endfunction

  function automatic int ref_pop(input code_word_t w);
    int n;
    n = 0;
    for (int i = 0; i <= DW; i++) n += int'(w[i]);
    return n;
  endfunction

  task automatic drive_and_sample(input logic [DW-1:0] d, input logic c);
    @(negedge clk);
    data_in = d;
    control = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b1;
    data_in = 7'b1111111;
    control = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%b want=%b", data_out, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got=%b want=%b", data_out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_before_edge got=%b want=%b", data_out, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 8'b11111111) begin
      errors++;
      $display("FAIL reset_first_load got=%b want=%b", data_out, 8'b11111111);
    end
  endtask

  task automatic test_directed;
    logic [DW-1:0] d_tab [6];
    logic          c_tab [6];
    code_word_t    e_tab [6];
    d_tab = '{7'b0000000, 7'b0000000, 7'b1010101, 7'b1010101, 7'b1110000, 7'b1110000};
    c_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    e_tab = '{8'b00000000, 8'b00000001, 8'b10101010, 8'b10101011, 8'b11100001, 8'b11100000};
    for (int i = 0; i < 6; i++) begin
      drive_and_sample(d_tab[i], c_tab[i]);
      checks++;
      if (data_out !== e_tab[i]) begin
        errors++;
        $display("FAIL directed_%0d got=%b want=%b", i, data_out, e_tab[i]);
      end
    end
  endtask

  task automatic test_sweep;
    int bad;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vv;
      code_word_t exp_w;
      vv = 8'(v);
      drive_and_sample(vv[7:1], vv[0]);
      exp_w = ref_word(vv[7:1], vv[0]);
      checks++;
      if (data_out !== exp_w || (ref_pop(data_out) % 2) != int'(vv[0])) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL sweep_%0d got=%b want=%b", v, data_out, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back;
    code_word_t exp_q[$];
    code_word_t exp_w;
    logic [DW-1:0] d;
    logic c;
    for (int i = 0; i < 200; i++) begin
      d = DW'($urandom);
      c = 1'($urandom);
      exp_q.push_back(ref_word(d, c));
      drive_and_sample(d, c);
      exp_w = exp_q.pop_front();
      checks++;
      if (data_out !== exp_w) begin
        errors++;
        $display("FAIL random_%0d got=%b want=%b", i, data_out, exp_w);
      end
    end
  endtask

  task automatic test_hold;
    logic [DW-1:0] d;
    logic c;
    code_word_t exp_w;
    d = DW'($urandom);
    c = 1'($urandom);
    exp_w = ref_word(d, c);
    drive_and_sample(d, c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (data_out !== exp_w) begin
        errors++;
        $display("FAIL hold_%0d got=%b want=%b", i, data_out, exp_w);
      end
    end
  endtask

  task automatic test_reset_midop;
    drive_and_sample(7'b0110011, 1'b1);
    @(negedge clk);
    data_in = 7'b1011001;
    control = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL midop_reset got=%b want=%b", data_out, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL midop_discard got=%b want=%b", data_out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_sample(7'b0001011, 1'b1);
    checks++;
    if (data_out !== ref_word(7'b0001011, 1'b1)) begin
      errors++;
      $display("FAIL midop_recover got=%b want=%b", data_out, ref_word(7'b0001011, 1'b1));
    end
  endtask

`ifdef STAVKA_A_ONES_COUNT_EN
  task automatic test_ones_count;
    logic [DW-1:0] d;
    logic c;
    drive_and_sample(7'b1111111, 1'b0);
    checks++;
    if (data_out !== 8'b11111111 || ones_count !== 4'd8) begin
      errors++;
      $display("FAIL ones_full_even got=%b/%0d want=%b/8", data_out, ones_count, 8'b11111111);
    end
    drive_and_sample(7'b1111111, 1'b1);
    checks++;
    if (data_out !== 8'b11111110 || ones_count !== 4'd7) begin
      errors++;
      $display("FAIL ones_full_odd got=%b/%0d want=%b/7", data_out, ones_count, 8'b11111110);
    end
    for (int i = 0; i < 50; i++) begin
      d = DW'($urandom);
      c = 1'($urandom);
      drive_and_sample(d, c);
      checks++;
      if (int'(ones_count) != ref_pop(ref_word(d, c))) begin
        errors++;
        $display("FAIL ones_rand_%0d got=%0d want=%0d", i, ones_count, ref_pop(ref_word(d, c)));
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ones_count !== 4'd0) begin
      errors++;
      $display("FAIL ones_reset got=%0d want=0", ones_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    data_in = '0;
    control = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL power_on_reset got=%b want=%b", data_out, 8'h00);
    end
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    test_hold();
    test_reset_midop();
`ifdef STAVKA_A_ONES_COUNT_EN
    test_ones_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
